vga_timing_2phase: RTL and testbench
====================================

Name: vga_timing_2phase

Overview:
- Generates 640x480@60 VGA timing for the donut renderer from a system clock running at twice the pixel rate.
- Each pixel position is held for two clk cycles. A `phase` bit marks which half is current: the renderer registers partial results in phase 0 and finishes the pixel in phase 1.
- Sits directly upstream of the renderer and drives its sync, blanking and pixel-coordinate inputs.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level
- V_SYNC_POL, 0, vsync active level

Ports:
- clk  in  1  system clock, 2x pixel clock
- rst_n  in  1  asynchronous reset, active low
- phase  out  1  0 = first half of pixel, 1 = second half
- hpos  out  10  current pixel column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_on  out  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- line_start  out  1  high for the single clk where hpos==0 and phase==0
- frame_start  out  1  high for the single clk where hpos==0, vpos==0 and phase==0

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset rst_n is asynchronous and active low.
  - Reset values: phase=0, hpos=0, vpos=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, display_on=1.
  - line_start and frame_start are 1 while phase=0 at (0,0), including the first cycle after reset release.
- Derived constants: H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK = 800. V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK = 525.
- Phase: phase toggles on every rising clk edge.
- Pixel advance:
  - hpos/vpos update only on the edge where phase goes 1->0, so both phases of a pixel see identical coordinates.
  - hpos increments. When it equals H_TOTAL-1 at that edge, it wraps to 0 and vpos increments.
  - When vpos equals V_TOTAL-1 and hpos wraps, vpos wraps to 0.
  - Counters never leave their ranges. Out-of-range values are impossible after reset.
- Syncs:
  - hsync is at H_SYNC_POL when hpos is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751; otherwise at the opposite level.
  - vsync is at V_SYNC_POL when vpos is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- Register timing:
  - hsync, vsync and display_on are registered from next-state counter values, so they change on the same clk edge as hpos/vpos, with zero skew relative to the coordinates.
  - No combinational path from any input to any output except the asynchronous reset.
- Pulses:
  - line_start and frame_start are decoded from registered state and last exactly one clk.
  - frame_start implies line_start.
- Per-frame counts:
  - Line period = 1600 clk. Frame period = 840000 clk.
  - hsync active = 192 clk per line. vsync active = 3200 clk per frame.
- Mid-operation reset: rst_n assertion at any point immediately forces all reset values, without waiting for a clock. The first edge after release starts phase 0 -> 1 of pixel (0,0).
- Width: 10-bit counters; parameters must give H_TOTAL and V_TOTAL at most 1024. Comparisons are unsigned.

Test Plan:
1. Reset then release: phase=0, hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, frame_start=1 and line_start=1 in cycle 0. Cycle 1: phase=1, hpos=0, frame_start=0. Cycle 2: hpos=1, phase=0.
2. Run one line:
   - hsync falls on the edge where hpos becomes 656 and rises when hpos becomes 752, 192 clk low.
   - display_on falls when hpos becomes 640.
   - hpos goes 799->0 with vpos 0->1 after 1600 clk; line_start pulses once.
3. Run to the frame end:
   - display_on stays 0 for lines 480..524.
   - vsync low exactly while vpos is 490..491 (3200 clk).
   - vpos goes 524->0 with hpos 799->0.
   - frame_start pulses again exactly 840000 clk after the first.
4. Coordinate stability: for every pixel, sampled hpos/vpos are equal in phase 0 and phase 1. Over 10000 clk there is no cycle where the counters change on a phase 0->1 edge.
5. Mid-line reset: assert rst_n at hpos=700, vpos=300, phase=1, between edges. Outputs return to reset values before the next clk edge. After release the sequence matches scenario 1.
6. Parameter override with H_DISPLAY=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1:
   - H_TOTAL=12, hsync low at hpos 9..10.
   - V_TOTAL=7, vsync low at vpos 5.
   - Frame period 168 clk.

Source files
------------

// File: rtl/vga_timing_2phase.sv
// VGA timing generator (640x480@60 by default) clocked at twice the pixel rate.
// Each pixel position is held for two clk cycles and `phase` marks which half is
// current. Every output is registered; sync/blanking/pulse flags are computed
// from the next-state counters so they change on the same edge as the coordinates.
//
// Ports:
//   clk         system clock, 2x pixel clock
//   rst_n       asynchronous reset, active low
//   phase       0 = first half of pixel, 1 = second half
//   hpos, vpos  current pixel column / line
//   hsync       horizontal sync (active level H_SYNC_POL)
//   vsync       vertical sync (active level V_SYNC_POL)
//   display_on  high inside the active picture
//   line_start  one-clk pulse at hpos==0, phase==0
//   frame_start one-clk pulse at hpos==0, vpos==0, phase==0
module vga_timing_2phase #(
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       phase,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    // Counters are 10 bits wide; larger timings cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
        $error("vga_timing_2phase: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic          phase_nxt;
    logic [CW-1:0] hpos_nxt;
    logic [CW-1:0] vpos_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic          display_nxt;
    logic          line_start_nxt;
    logic          frame_start_nxt;

    // Next-state counters and the flags derived from them.
    always_comb begin
        phase_nxt = ~phase;
        hpos_nxt  = hpos;
        vpos_nxt  = vpos;

        // Coordinates advance only when leaving phase 1.
        if (phase) begin
            if (hpos == CW'(H_TOTAL - 1)) begin
                hpos_nxt = '0;
                if (vpos == CW'(V_TOTAL - 1)) begin
                    vpos_nxt = '0;
                end else begin
                    vpos_nxt = vpos + CW'(1);
                end
            end else begin
                hpos_nxt = hpos + CW'(1);
            end
        end

        hsync_nxt = ((hpos_nxt >= CW'(HS_START)) && (hpos_nxt <= CW'(HS_END)))
                    ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_nxt = ((vpos_nxt >= CW'(VS_START)) && (vpos_nxt <= CW'(VS_END)))
                    ? V_SYNC_POL : ~V_SYNC_POL;
        display_nxt     = (hpos_nxt < CW'(H_DISPLAY)) && (vpos_nxt < CW'(V_DISPLAY));
        line_start_nxt  = ~phase_nxt && (hpos_nxt == '0);
        frame_start_nxt = line_start_nxt && (vpos_nxt == '0);
    end

    // State and output registers; reset state is phase 0 of pixel (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            phase       <= phase_nxt;
            hpos        <= hpos_nxt;
            vpos        <= vpos_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            display_on  <= display_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_2phase.sv
// Directed bench for vga_timing_2phase: default 640x480 instance plus a tiny
// parameter-override instance. Expected values come from cycle-count arithmetic.
module tb_vga_timing_2phase;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rst_s;

    logic       phase_b, hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [9:0] hpos_b, vpos_b;
    logic       phase_s, hsync_s, vsync_s, de_s, ls_s, fs_s;
    logic [9:0] hpos_s, vpos_s;

    vga_timing_2phase u_big (
        .clk(clk), .rst_n(rst_n), .phase(phase_b), .hpos(hpos_b), .vpos(vpos_b),
        .hsync(hsync_b), .vsync(vsync_b), .display_on(de_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_2phase #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .clk(clk), .rst_n(rst_s), .phase(phase_s), .hpos(hpos_s), .vpos(vpos_s),
        .hsync(hsync_s), .vsync(vsync_s), .display_on(de_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    int errors = 0;
    int checks = 0;

    int hs_low, de_cnt, ls_cnt, fs_cnt, viol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs t clocks after reset release, from timing arithmetic.
    task automatic exp_calc(input int t, input int ht, input int hd, input int hs0,
                            input int hs1, input int vt, input int vd, input int vs0,
                            input int vs1, output int ph, output int h, output int v,
                            output int hsx, output int vsx, output int de,
                            output int ls, output int fs);
        ph  = t % 2;
        h   = (t / 2) % ht;
        v   = (t / (2 * ht)) % vt;
        hsx = (h >= hs0 && h <= hs1) ? 0 : 1;
        vsx = (v >= vs0 && v <= vs1) ? 0 : 1;
        de  = (h < hd && v < vd) ? 1 : 0;
        ls  = (ph == 0 && h == 0) ? 1 : 0;
        fs  = (ls == 1 && v == 0) ? 1 : 0;
    endtask

    task automatic chk_big(input int t);
        int ph, h, v, hsx, vsx, de, ls, fs;
        exp_calc(t, 800, 640, 656, 751, 525, 480, 490, 491, ph, h, v, hsx, vsx, de, ls, fs);
        check("b_phase", 32'(phase_b), ph);
        check("b_hpos", 32'(hpos_b), h);
        check("b_vpos", 32'(vpos_b), v);
        check("b_hsync", 32'(hsync_b), hsx);
        check("b_vsync", 32'(vsync_b), vsx);
        check("b_display_on", 32'(de_b), de);
        check("b_line_start", 32'(ls_b), ls);
        check("b_frame_start", 32'(fs_b), fs);
    endtask

    task automatic chk_small(input int t);
        int ph, h, v, hsx, vsx, de, ls, fs;
        exp_calc(t, 12, 8, 9, 10, 7, 4, 5, 5, ph, h, v, hsx, vsx, de, ls, fs);
        check("s_phase", 32'(phase_s), ph);
        check("s_hpos", 32'(hpos_s), h);
        check("s_vpos", 32'(vpos_s), v);
        check("s_hsync", 32'(hsync_s), hsx);
        check("s_vsync", 32'(vsync_s), vsx);
        check("s_display_on", 32'(de_s), de);
        check("s_line_start", 32'(ls_s), ls);
        check("s_frame_start", 32'(fs_s), fs);
    endtask

    task automatic check_big_reset(input string tag);
        check({tag, "_phase"}, 32'(phase_b), 0);
        check({tag, "_hpos"}, 32'(hpos_b), 0);
        check({tag, "_vpos"}, 32'(vpos_b), 0);
        check({tag, "_hsync"}, 32'(hsync_b), 1);
        check({tag, "_vsync"}, 32'(vsync_b), 1);
        check({tag, "_display_on"}, 32'(de_b), 1);
        check({tag, "_line_start"}, 32'(ls_b), 1);
        check({tag, "_frame_start"}, 32'(fs_b), 1);
    endtask

    // Runs n sampled cycles of the default instance, starting at t=0; ends on the last sample.
    task automatic run_big(input int n);
        logic [9:0] ph_prev, pv_prev;
        hs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; viol = 0;
        ph_prev = '0; pv_prev = '0;
        for (int t = 0; t < n; t++) begin
            chk_big(t);
            if (t < 1600 && hsync_b == 1'b0) hs_low++;
            if (t < 1600 && de_b == 1'b1) de_cnt++;
            if (ls_b) ls_cnt++;
            if (fs_b) fs_cnt++;
            if (t > 0 && (hpos_b != ph_prev || vpos_b != pv_prev) && phase_b != 1'b0) viol++;
            ph_prev = hpos_b;
            pv_prev = vpos_b;
            if (t < n - 1) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int fs_first, fs_second, fs_seen, vs_low;
        rst_n = 1'b0;
        rst_s = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_big_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // First segment ends at pixel (700,3) in phase 1: t = 3*1600 + 700*2 + 1.
        run_big(6202);
        check("line0_hsync_low_clks", 32'(hs_low), 192);
        check("line0_display_clks", 32'(de_cnt), 1280);
        check("seg1_line_starts", 32'(ls_cnt), 4);
        check("seg1_frame_starts", 32'(fs_cnt), 1);
        check("seg1_phase1_changes", 32'(viol), 0);
        check("pre_reset_hpos", 32'(hpos_b), 700);
        check("pre_reset_vpos", 32'(vpos_b), 3);
        check("pre_reset_phase", 32'(phase_b), 1);

        // Mid-line asynchronous reset between clock edges.
        rst_n = 1'b0;
        #1;
        check_big_reset("async_rst");
        @(negedge clk);
        #1;
        check_big_reset("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        run_big(10000);
        check("seg2_hsync_low_clks", 32'(hs_low), 192);
        check("seg2_display_clks", 32'(de_cnt), 1280);
        check("seg2_line_starts", 32'(ls_cnt), 7);
        check("seg2_frame_starts", 32'(fs_cnt), 1);
        check("seg2_phase1_changes", 32'(viol), 0);

        // Parameter-override instance: two full 168-clk frames.
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("s_rst_hsync", 32'(hsync_s), 1);
        check("s_rst_frame_start", 32'(fs_s), 1);
        @(negedge clk);
        rst_s = 1'b1;
        #1;
        fs_first = -1; fs_second = -1; fs_seen = 0; vs_low = 0;
        for (int t = 0; t < 336; t++) begin
            chk_small(t);
            if (fs_s) begin
                if (fs_seen == 0) fs_first = t;
                else if (fs_seen == 1) fs_second = t;
                fs_seen++;
            end
            if (vsync_s == 1'b0) vs_low++;
            @(negedge clk);
            #1;
        end
        check("s_frame_starts", 32'(fs_seen), 2);
        check("s_frame_period", 32'(fs_second - fs_first), 168);
        check("s_vsync_low_clks", 32'(vs_low), 48);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
